// File: rtl/tcdm_pkg.sv
// Shared types and constants for the TCDM request multiplexer.
// Holds the request bundle type, the performance counter width and a
// small helper that sizes index/pointer fields with a minimum of one bit.
package tcdm_pkg;

  localparam int unsigned TcdmAddrWidth = 32;
  localparam int unsigned TcdmDataWidth = 32;
  localparam int unsigned TcdmBeWidth   = TcdmDataWidth / 8;

  localparam int unsigned PERF_CNT_W = 32;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0] add;
    logic                     wen;
    logic [TcdmDataWidth-1:0] wdata;
    logic [TcdmBeWidth-1:0]   be;
  } tcdm_req_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_id_fifo.sv
// In-order ID FIFO: remembers which requester issued each outstanding
// transaction so responses can be routed back. Depth need not be a power
// of two; pointers wrap explicitly at Depth. Push when full and pop when
// empty are ignored so the occupancy can never go out of range.
module tcdm_id_fifo
  import tcdm_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = idx_width(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wptr_r;
  logic [PtrW-1:0]  rptr_r;
  logic [CntW-1:0]  cnt_r;
  logic             push_s;
  logic             pop_s;

  // Advance a pointer by one, wrapping at the last entry.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_r == DepthCnt);
  assign empty_o = (cnt_r == {CntW{1'b0}});
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = mem_r[rptr_r];

  // Storage: write the incoming ID at the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wptr_r] <= data_i;
    end else begin
      mem_r[wptr_r] <= mem_r[wptr_r];
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= {PtrW{1'b0}};
      rptr_r <= {PtrW{1'b0}};
      cnt_r  <= {CntW{1'b0}};
    end else begin
      wptr_r <= push_s ? next_ptr(wptr_r) : wptr_r;
      rptr_r <= pop_s ? next_ptr(rptr_r) : rptr_r;
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CntW'(1);
        2'b01:   cnt_r <= cnt_r - CntW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_req_mux_chk.sv
// Protocol checker for tcdm_req_mux. Flags a response that arrives while
// no transaction is outstanding; such a response is dropped by the mux.
// err_cnt_o counts these events since the last reset.
module tcdm_req_mux_chk
  import tcdm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vld_i,
  input  logic       empty_i,
  output logic [7:0] err_cnt_o
);

  // Count responses that arrive with an empty ID FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= 8'd0;
    end else if (vld_i && empty_i) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end else begin
      err_cnt_o <= err_cnt_o;
    end
  end

  // Report an orphan response when it is sampled.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      vld_with_empty_fifo : assert (!(vld_i && empty_i))
        else $warning("tcdm_req_mux: response with no outstanding transaction, dropped");
    end
  end

endmodule

// File: rtl/tcdm_req_mux.sv
// tcdm_req_mux: shares one TCDM initiator port among NumReq requesters.
// Round-robin arbitration, in-order ID FIFO for response routing and a
// cap of MaxOutstanding transactions in flight.
// Optional performance counters are enabled with TCDM_REQ_MUX_PERF_EN.
module tcdm_req_mux
  import tcdm_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          WriteRespOn    = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*AddrWidth-1:0]   add_i,
  input  logic [NumReq-1:0]             wen_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             vld_o,
  output logic [NumReq*DataWidth-1:0]   rdata_o,
  output logic                          req_o,
  output logic [AddrWidth-1:0]          add_o,
  output logic                          wen_o,
  output logic [DataWidth-1:0]          wdata_o,
  output logic [BeWidth-1:0]            be_o,
  input  logic                          gnt_i,
  input  logic                          vld_i,
  input  logic [DataWidth-1:0]          rdata_i,
  output logic [PERF_CNT_W-1:0]         perf_grant_o,
  output logic [PERF_CNT_W-1:0]         perf_stall_o
);

  localparam int unsigned IdxW = idx_width(NumReq);
  localparam logic [IdxW-1:0] LastReq = IdxW'(NumReq - 1);

  logic [IdxW-1:0] rr_ptr_r;
  logic [IdxW-1:0] winner_s;
  logic [IdxW-1:0] sel_s;
  logic [IdxW-1:0] fifo_head_s;
  logic            found_s;
  logic            any_req_s;
  logic            needs_slot_s;
  logic            blocked_s;
  logic            fire_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  // Round-robin search: first active request at or after the pointer.
  always_comb begin
    logic [IdxW-1:0] idx_v;
    idx_v    = {IdxW{1'b0}};
    winner_s = {IdxW{1'b0}};
    found_s  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx_v = IdxW'((32'(rr_ptr_r) + i) % NumReq);
      if (!found_s && req_i[idx_v]) begin
        found_s  = 1'b1;
        winner_s = idx_v;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign any_req_s = |req_i;
  // A store takes no FIFO slot when writes are fire-and-forget, so full
  // does not hold it back. The full decision ignores a same-cycle pop.
  assign needs_slot_s = WriteRespOn | ~wen_i[winner_s];
  assign blocked_s    = fifo_full_s & needs_slot_s;
  assign req_o        = any_req_s & ~blocked_s;
  assign fire_s       = req_o & gnt_i;
  assign push_s       = fire_s & needs_slot_s;
  assign pop_s        = vld_i & ~fifo_empty_s;

  // Request field mux; idle fields show requester 0.
  always_comb begin
    sel_s   = req_o ? winner_s : {IdxW{1'b0}};
    add_o   = add_i[32'(sel_s) * AddrWidth +: AddrWidth];
    wen_o   = wen_i[sel_s];
    wdata_o = wdata_i[32'(sel_s) * DataWidth +: DataWidth];
    be_o    = be_i[32'(sel_s) * BeWidth +: BeWidth];
  end

  // Grant goes back only to the winner, and only when the port fires.
  always_comb begin
    gnt_o           = {NumReq{1'b0}};
    gnt_o[winner_s] = fire_s;
  end

  // Response routing: one-hot of the oldest outstanding ID, same cycle.
  always_comb begin
    vld_o = {NumReq{1'b0}};
    if (pop_s) begin
      vld_o[fifo_head_s] = 1'b1;
    end else begin
      vld_o = {NumReq{1'b0}};
    end
  end

  assign rdata_o = {NumReq{rdata_i}};

  // Round-robin pointer moves past the winner on every fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= {IdxW{1'b0}};
    end else if (fire_s) begin
      rr_ptr_r <= (winner_s == LastReq) ? {IdxW{1'b0}} : winner_s + IdxW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  tcdm_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (winner_s),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef TCDM_REQ_MUX_PERF_EN
  logic [PERF_CNT_W-1:0] perf_grant_r;
  logic [PERF_CNT_W-1:0] perf_stall_r;
  logic                  stall_s;

  assign stall_s = any_req_s & (blocked_s | ~gnt_i);

  // Free-running grant and stall counters, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_grant_r <= {PERF_CNT_W{1'b0}};
      perf_stall_r <= {PERF_CNT_W{1'b0}};
    end else begin
      perf_grant_r <= fire_s ? perf_grant_r + PERF_CNT_W'(1) : perf_grant_r;
      perf_stall_r <= stall_s ? perf_stall_r + PERF_CNT_W'(1) : perf_stall_r;
    end
  end

  assign perf_grant_o = perf_grant_r;
  assign perf_stall_o = perf_stall_r;
`else
  assign perf_grant_o = {PERF_CNT_W{1'b0}};
  assign perf_stall_o = {PERF_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_tcdm_req_mux.sv
// Directed testbench for tcdm_req_mux (NumReq=4, MaxOutstanding=4).
// A second instance with WriteRespOn=0 covers fire-and-forget stores.
module tb_tcdm_req_mux;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_ni;
  logic [NR-1:0]     req_i, wen_i;
  logic [NR*AW-1:0]  add_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR*BW-1:0]  be_i;
  logic              gnt_i, vld_i;
  logic [DW-1:0]     rdata_i;

  logic [NR-1:0]     gnt_o, vld_o;
  logic [NR*DW-1:0]  rdata_o;
  logic              req_o, wen_o;
  logic [AW-1:0]     add_o;
  logic [DW-1:0]     wdata_o;
  logic [BW-1:0]     be_o;
  logic [31:0]       perf_grant_o, perf_stall_o;

  logic [NR-1:0]     ff_gnt_o, ff_vld_o;
  logic [NR*DW-1:0]  ff_rdata_o;
  logic              ff_req_o, ff_wen_o;
  logic [AW-1:0]     ff_add_o;
  logic [DW-1:0]     ff_wdata_o;
  logic [BW-1:0]     ff_be_o;
  logic [31:0]       ff_perf_grant_o, ff_perf_stall_o;

  logic [7:0]        err_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_g, exp_v;
  logic [31:0] exp_a;

  tcdm_req_mux #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .MaxOutstanding(4), .WriteRespOn(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i),
    .perf_grant_o(perf_grant_o), .perf_stall_o(perf_stall_o)
  );

  tcdm_req_mux #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .MaxOutstanding(4), .WriteRespOn(1'b0)
  ) dut_ff (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(ff_gnt_o), .vld_o(ff_vld_o), .rdata_o(ff_rdata_o),
    .req_o(ff_req_o), .add_o(ff_add_o), .wen_o(ff_wen_o), .wdata_o(ff_wdata_o), .be_o(ff_be_o),
    .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i),
    .perf_grant_o(ff_perf_grant_o), .perf_stall_o(ff_perf_stall_o)
  );

  tcdm_req_mux_chk u_chk (
    .clk_i(clk), .rst_ni(rst_ni), .vld_i(vld_i),
    .empty_i(dut.fifo_empty_s), .err_cnt_o(err_cnt)
  );

  task automatic drive(input logic [3:0] r, input logic g, input logic v, input logic [31:0] rd);
    @(negedge clk);
    req_i = r; gnt_i = g; vld_i = v; rdata_i = rd;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_ni = 1'b0; req_i = 4'b0000; gnt_i = 1'b0; vld_i = 1'b0; wen_i = 4'b0000;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; req_i = 4'b0000; gnt_i = 1'b0; vld_i = 1'b0; wen_i = 4'b0000; rdata_i = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req_o); end
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt_o); end
    checks++; if (vld_o !== 4'b0000) begin errors++; $display("FAIL reset_vld: got %b expected 0000", vld_o); end
    checks++; if (add_o !== 32'h0000_1000) begin errors++; $display("FAIL reset_add_idx0: got %h expected 00001000", add_o); end
    checks++; if (perf_grant_o !== 32'd0) begin errors++; $display("FAIL reset_perf_grant: got %0d expected 0", perf_grant_o); end
    checks++; if (perf_stall_o !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall_o); end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read;
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, 1'b1, logic'(k > 0), 32'h100 + 32'(k));
      exp_v = (k > 0) ? 4'b0001 : 4'b0000;
      checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL single_gnt k=%0d: got %b expected 0001", k, gnt_o); end
      checks++; if (add_o !== 32'h0000_1000) begin errors++; $display("FAIL single_add k=%0d: got %h expected 00001000", k, add_o); end
      checks++; if (vld_o !== exp_v) begin errors++; $display("FAIL single_vld k=%0d: got %b expected %b", k, vld_o, exp_v); end
      checks++; if (rdata_o !== {4{32'h100 + 32'(k)}}) begin errors++; $display("FAIL single_rdata k=%0d: got %h", k, rdata_o); end
    end
    drive(4'b0000, 1'b0, 1'b1, 32'h200);
    checks++; if (vld_o !== 4'b0001) begin errors++; $display("FAIL single_last_vld: got %b expected 0001", vld_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL single_idle_req: got %b expected 0", req_o); end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    checks++; if (vld_o !== 4'b0000) begin errors++; $display("FAIL single_no_vld: got %b expected 0000", vld_o); end
  endtask

  task automatic test_fairness;
    int gcnt [4];
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    do_reset;
    for (int k = 0; k < 100; k++) begin
      drive(4'b1111, 1'b1, logic'(k > 0), 32'(k));
      exp_g = 4'b0001 << (k % 4);
      exp_v = (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
      exp_a = 32'h1000 + 32'(16 * (k % 4));
      for (int i = 0; i < 4; i++) if (gnt_o[i]) gcnt[i]++;
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL fair_gnt k=%0d: got %b expected %b", k, gnt_o, exp_g); end
      checks++; if (vld_o !== exp_v) begin errors++; $display("FAIL fair_vld k=%0d: got %b expected %b", k, vld_o, exp_v); end
      checks++; if (add_o !== exp_a) begin errors++; $display("FAIL fair_add k=%0d: got %h expected %h", k, add_o, exp_a); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (gcnt[i] !== 25) begin errors++; $display("FAIL fair_count req=%0d: got %0d expected 25", i, gcnt[i]); end
    end
    drive(4'b0000, 1'b0, 1'b1, 32'h0);
    checks++; if (vld_o !== 4'b1000) begin errors++; $display("FAIL fair_last_vld: got %b expected 1000", vld_o); end
`ifdef TCDM_REQ_MUX_PERF_EN
    checks++; if (perf_grant_o !== 32'd100) begin errors++; $display("FAIL fair_perf_grant: got %0d expected 100", perf_grant_o); end
    checks++; if (perf_stall_o !== 32'd0) begin errors++; $display("FAIL fair_perf_stall: got %0d expected 0", perf_stall_o); end
`else
    checks++; if (perf_grant_o !== 32'd0) begin errors++; $display("FAIL fair_perf_off: got %0d expected 0", perf_grant_o); end
`endif
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 4; k++) begin
      drive(4'b1111, 1'b1, 1'b0, 32'h0);
      exp_g = 4'b0001 << k;
      checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL bp_req k=%0d: got %b expected 1", k, req_o); end
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL bp_gnt k=%0d: got %b expected %b", k, gnt_o, exp_g); end
    end
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %b expected 0", req_o); end
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL bp_full_gnt: got %b expected 0000", gnt_o); end
    checks++; if (add_o !== 32'h0000_1000) begin errors++; $display("FAIL bp_full_add: got %h expected 00001000", add_o); end
    drive(4'b1111, 1'b1, 1'b1, 32'hAA);
    checks++; if (vld_o !== 4'b0001) begin errors++; $display("FAIL bp_pop_vld: got %b expected 0001", vld_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: got %b expected 0", req_o); end
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %b expected 1", req_o); end
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL bp_resume_gnt: got %b expected 0001", gnt_o); end
    for (int j = 0; j < 4; j++) begin
      drive(4'b0000, 1'b0, 1'b1, 32'hB0 + 32'(j));
      exp_v = 4'b0010 << j;
      if (j == 3) exp_v = 4'b0001;
      checks++; if (vld_o !== exp_v) begin errors++; $display("FAIL bp_drain j=%0d: got %b expected %b", j, vld_o, exp_v); end
    end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_interleaved;
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL il_gnt3: got %b expected 1000", gnt_o); end
    checks++; if (add_o !== 32'h0000_1030) begin errors++; $display("FAIL il_add3: got %h expected 00001030", add_o); end
    checks++; if (wdata_o !== 32'hD000_0003) begin errors++; $display("FAIL il_wdata3: got %h expected d0000003", wdata_o); end
    checks++; if (be_o !== 4'b1000) begin errors++; $display("FAIL il_be3: got %b expected 1000", be_o); end
    checks++; if (wen_o !== 1'b0) begin errors++; $display("FAIL il_wen3: got %b expected 0", wen_o); end
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL il_gnt0: got %b expected 0001", gnt_o); end
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL il_gnt2: got %b expected 0100", gnt_o); end
    checks++; if (add_o !== 32'h0000_1020) begin errors++; $display("FAIL il_add2: got %h expected 00001020", add_o); end
    drive(4'b0000, 1'b0, 1'b1, 32'hA);
    checks++; if (vld_o !== 4'b1000) begin errors++; $display("FAIL il_vld_a: got %b expected 1000", vld_o); end
    checks++; if (rdata_o[3*DW +: DW] !== 32'hA) begin errors++; $display("FAIL il_rdata_a: got %h expected a", rdata_o[3*DW +: DW]); end
    drive(4'b0000, 1'b0, 1'b1, 32'hB);
    checks++; if (vld_o !== 4'b0001) begin errors++; $display("FAIL il_vld_b: got %b expected 0001", vld_o); end
    drive(4'b0000, 1'b0, 1'b1, 32'hC);
    checks++; if (vld_o !== 4'b0100) begin errors++; $display("FAIL il_vld_c: got %b expected 0100", vld_o); end
    checks++; if (rdata_o[2*DW +: DW] !== 32'hC) begin errors++; $display("FAIL il_rdata_c: got %h expected c", rdata_o[2*DW +: DW]); end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_midflight;
    drive(4'b0010, 1'b1, 1'b0, 32'h0);
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL mf_gnt1: got %b expected 0010", gnt_o); end
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL mf_gnt2: got %b expected 0100", gnt_o); end
    @(negedge clk);
    req_i = 4'b0000; gnt_i = 1'b0; vld_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    #1;
    checks++; if (perf_grant_o !== 32'd0) begin errors++; $display("FAIL mf_perf_grant: got %0d expected 0", perf_grant_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mf_req: got %b expected 0", req_o); end
    drive(4'b0000, 1'b0, 1'b1, 32'hDD);
    checks++; if (vld_o !== 4'b0000) begin errors++; $display("FAIL mf_vld_dropped: got %b expected 0000", vld_o); end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mf_assert_count: got %0d expected 1", err_cnt); end
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL mf_rr_ptr: got %b expected 0001", gnt_o); end
    drive(4'b0000, 1'b0, 1'b1, 32'h5);
    checks++; if (vld_o !== 4'b0001) begin errors++; $display("FAIL mf_post_vld: got %b expected 0001", vld_o); end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_write_ff;
    do_reset;
    wen_i = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      drive(4'b0100, 1'b1, 1'b0, 32'h0);
      checks++; if (ff_gnt_o !== 4'b0100) begin errors++; $display("FAIL ff_gnt k=%0d: got %b expected 0100", k, ff_gnt_o); end
      checks++; if (ff_wen_o !== 1'b1) begin errors++; $display("FAIL ff_wen k=%0d: got %b expected 1", k, ff_wen_o); end
      checks++; if (ff_vld_o !== 4'b0000) begin errors++; $display("FAIL ff_vld k=%0d: got %b expected 0000", k, ff_vld_o); end
    end
    drive(4'b0000, 1'b0, 1'b1, 32'hEE);
    checks++; if (ff_vld_o !== 4'b0000) begin errors++; $display("FAIL ff_empty_vld: got %b expected 0000", ff_vld_o); end
    wen_i = 4'b0000;
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    checks++; if (ff_gnt_o !== 4'b0100) begin errors++; $display("FAIL ff_read_gnt: got %b expected 0100", ff_gnt_o); end
    drive(4'b0000, 1'b0, 1'b1, 32'h77);
    checks++; if (ff_vld_o !== 4'b0100) begin errors++; $display("FAIL ff_read_vld: got %b expected 0100", ff_vld_o); end
    checks++; if (ff_rdata_o[2*DW +: DW] !== 32'h77) begin errors++; $display("FAIL ff_read_rdata: got %h expected 77", ff_rdata_o[2*DW +: DW]); end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      add_i[i*AW +: AW]   = 32'h1000 + 32'(16 * i);
      wdata_i[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      be_i[i*BW +: BW]    = 4'b0001 << i;
    end
    test_reset;
    test_single_read;
    test_fairness;
    test_backpressure;
    test_interleaved;
    test_reset_midflight;
    test_write_ff;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tcdm_req_mux.md
Name: tcdm_req_mux

Overview:
- Shares one initiator port of the TCDM interconnect among NumReq local requesters, for example a core's LSU, a DMA and an accelerator behind one port.
- Arbitration is round-robin.
- Requester IDs of outstanding transactions are kept in an in-order ID FIFO, so each vld/rdata from the interconnect returns to the requester that issued it.
- The block limits outstanding transactions to MaxOutstanding.

Parameters:
- NumReq, 4, number of local requesters (≥2; need not be a power of 2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width.
- BeWidth, DataWidth/8, byte-enable width.
- MaxOutstanding, 4, ID FIFO depth (≥1; need not be a power of 2).
- WriteRespOn, 1, 1: the interconnect returns vld for writes, so writes occupy FIFO slots. 0: writes are fire-and-forget.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  requester request
- add_i  in  NumReq×AddrWidth  address
- wen_i  in  NumReq  1 store, 0 load
- wdata_i  in  NumReq×DataWidth  write data
- be_i  in  NumReq×BeWidth  byte enable
- gnt_o  out  NumReq  grant, combinational
- vld_o  out  NumReq  response valid, one-hot or zero
- rdata_o  out  NumReq×DataWidth  read data, rdata_i broadcast to all requesters
- req_o  out  1  request to interconnect
- add_o / wen_o / wdata_o / be_o  out  AddrWidth / 1 / DataWidth / BeWidth  muxed request fields
- gnt_i  in  1  interconnect grant
- vld_i  in  1  interconnect response valid
- rdata_i  in  DataWidth  interconnect read data
- perf_grant_o  out  32  granted-transaction count; zero when the optional feature is off
- perf_stall_o  out  32  stall-cycle count; zero when the optional feature is off

Behaviour:
- Reset is rst_ni asynchronous active-low; the clock is clk_i.
- Reset state:
  - rr pointer = 0; FIFO empty; perf counters 0.
  - Outputs are combinational from this state: req_o=0, gnt_o=0, vld_o=0.
- Arbitration (combinational):
  - Winner = first asserted req_i at index ≥ rr pointer, wrapping modulo NumReq.
  - req_o = |req_i & ~full, where full = FIFO full.
  - Request fields are muxed from the winner. When req_o=0, the fields hold the index-0 values.
  - gnt_o[winner] = gnt_i & req_o; all other gnt_o bits are 0.
- Handshake:
  - A transaction fires when req_o & gnt_i.
  - Requesters hold req_i and all fields stable until granted.
  - A requester that is not granted is not dropped; it competes again next cycle.
- rr pointer:
  - On fire, the pointer becomes (winner+1) mod NumReq, including wrap from NumReq-1 to 0.
  - Without a fire it holds.
- ID FIFO:
  - Push winner index on fire when (~wen of the winner | WriteRespOn).
  - Pop on vld_i.
  - vld_o = vld_i ? onehot(FIFO head) : 0, same cycle (zero added latency on the response path).
  - Responses are assumed in order. The interconnect latency is ≥1 cycle, so push and pop never target the same entry in one cycle.
- Full:
  - Stall is decided on full alone, even if a pop occurs that cycle: no bypass, for a shorter timing path.
  - Push and pop in the same cycle when not full: count unchanged.
- Empty:
  - vld_i with the FIFO empty is a protocol error: vld_o=0, no state change.
  - Simulation assertion fires.
- Write with WriteRespOn=0: the grant completes the transaction; a store is not throttled by full.
- Reset mid-operation:
  - The FIFO and pointer are cleared.
  - Responses still in flight after reset hit the empty case and are dropped.
- Counter widths: the FIFO count is $clog2(MaxOutstanding+1) bits and pointers are $clog2(MaxOutstanding) bits (minimum 1), wrapping at MaxOutstanding.

Optional Feature:
- Macro: TCDM_REQ_MUX_PERF_EN.
- When defined:
  - perf_grant_o increments on every fire.
  - perf_stall_o increments each cycle with |req_i & (full | ~gnt_i).
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: both outputs are tied to 0 and no flops are inferred.

Decomposition:
- Shared package tcdm_pkg holds:
  - typedef tcdm_req_t {add, wen, wdata, be}, parameterised through localparams matching AddrWidth/DataWidth.
  - constant PERF_CNT_W=32.
- One sub-module: tcdm_id_fifo.
  - Ports: push, pop, data in, head out, full, empty.
  - Parameters: depth and width $clog2(NumReq).
- The rr arbiter stays inline in tcdm_req_mux.

Test Plan:
- Single-requester reads:
  - Stimulus: req_i=0001, gnt_i=1 every cycle, vld_i 1 cycle later.
  - Expected: gnt_o=0001 each cycle; vld_o=0001 one cycle after each grant; rdata_o=rdata_i.
- Fairness:
  - Stimulus: req_i=1111 held, gnt_i=1, MaxOutstanding=4, responses 1 cycle late.
  - Expected: grant order 0,1,2,3,0,…; each requester gets exactly 25 grants in 100 cycles.
- Back-pressure at full:
  - Stimulus: 4 reads granted, no vld_i.
  - Expected: req_o=0 from cycle 5.
  - Then one vld_i: routed to the first ID. req_o=1 the next cycle, not the same cycle.
- Write fire-and-forget:
  - Stimulus: WriteRespOn=0, 10 consecutive stores from requester 2, no vld_i.
  - Expected: all 10 granted; FIFO stays empty; no vld_o.
- Interleaved routing:
  - Stimulus: reads from requesters 3,0,2 granted; responses rdata 0xA,0xB,0xC.
  - Expected: vld_o=1000,0001,0100 in that order.
- Reset mid-flight:
  - Stimulus: 2 reads outstanding, pulse rst_ni, then vld_i.
  - Expected: vld_o stays 0, error assertion fires, rr pointer=0.
  - With TCDM_REQ_MUX_PERF_EN: perf_grant_o=0.
